// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module  : core_pkg
// Brief   : Shared types for the five-stage core: words, register indices and
//           the hazard controller state encoding.
// Revision: 1.0
// ============================================================================
package core_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  reg_idx_t;

    localparam logic [0:0] c_st_run      = 1'b0;
    localparam logic [0:0] c_st_mdu_wait = 1'b1;

    typedef enum logic [0:0] {
        HZ_RUN      = c_st_run,
        HZ_MDU_WAIT = c_st_mdu_wait
    } hz_state_t;

endpackage
`default_nettype wire

// File: rtl/hz_loaduse_detect.sv
`default_nettype none
// ============================================================================
// Module  : hz_loaduse_detect
// Brief   : Pure comparator flagging a decode-stage read of a register that an
//           in-flight EX-stage load has not yet produced.
// Revision: 1.0
// ============================================================================
module hz_loaduse_detect
    import core_pkg::*;
(
    input  reg_idx_t i_d_rs1,
    input  reg_idx_t i_d_rs2,
    input  logic     i_d_rs1_used,
    input  logic     i_d_rs2_used,
    input  logic     i_d_valid,
    input  reg_idx_t i_e_rd,
    input  logic     i_e_is_load,
    input  logic     i_e_valid,
    output logic     o_hazard
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = i_d_rs1_used & (i_d_rs1 == i_e_rd);
    assign w_rs2_hit = i_d_rs2_used & (i_d_rs2 == i_e_rd);

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign o_hazard = i_e_valid & i_e_is_load & i_d_valid & (i_e_rd != '0)
                    & (w_rs1_hit | w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl
// Brief   : Load-use interlock, taken-branch redirect and MDU occupancy stall
//           control for the five-stage core, with stall/flush perf counters.
// Revision: 1.0
// ============================================================================
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  reg_idx_t         d_rs1,
    input  reg_idx_t         d_rs2,
    input  logic             d_rs1_used,
    input  logic             d_rs2_used,
    input  logic             d_valid,
    input  reg_idx_t         e_rd,
    input  logic             e_is_load,
    input  logic             e_valid,
    input  logic             e_branch_taken,
    input  word_t            e_branch_target,
    input  logic             e_mdu_start,
    input  logic             mdu_done,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic             branch_taken,
    output word_t            branch_target,
    output logic             mdu_timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int                  c_wcnt_w    = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [c_wcnt_w-1:0] c_wcnt_last = c_wcnt_w'(MDU_TIMEOUT - 1);

    hz_state_t           r_state_q;
    hz_state_t           w_state_d;
    logic [c_wcnt_w-1:0] r_wcnt_q;
    logic [c_wcnt_w-1:0] w_wcnt_d;
    logic                r_err_q;
    logic                w_err_d;
    logic [CNT_W-1:0]    r_stall_cnt_q;
    logic [CNT_W-1:0]    w_stall_cnt_d;
    logic [CNT_W-1:0]    r_flush_cnt_q;
    logic [CNT_W-1:0]    w_flush_cnt_d;
    logic                w_load_use;

    hz_loaduse_detect u_loaduse (
        .i_d_rs1      (d_rs1),
        .i_d_rs2      (d_rs2),
        .i_d_rs1_used (d_rs1_used),
        .i_d_rs2_used (d_rs2_used),
        .i_d_valid    (d_valid),
        .i_e_rd       (e_rd),
        .i_e_is_load  (e_is_load),
        .i_e_valid    (e_valid),
        .o_hazard     (w_load_use)
    );

    always_comb begin
        stall_f       = 1'b0;
        stall_d       = 1'b0;
        flush_d       = 1'b0;
        flush_e       = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        w_state_d     = r_state_q;
        w_wcnt_d      = r_wcnt_q;
        w_err_d       = r_err_q;

        // Reset forces every control output low regardless of pipeline inputs.
        if (!rst) begin
            case (r_state_q)
                HZ_RUN: begin
                    if (e_branch_taken) begin
                        branch_taken  = 1'b1;
                        branch_target = e_branch_target;
                        flush_d       = 1'b1;
                        flush_e       = 1'b1;
                    end else begin
                        if (w_load_use) begin
                            stall_f = 1'b1;
                            stall_d = 1'b1;
                            flush_e = 1'b1;
                        end
                        if (e_valid && e_mdu_start) begin
                            w_state_d = HZ_MDU_WAIT;
                            w_wcnt_d  = '0;
                        end
                    end
                end
                HZ_MDU_WAIT: begin
                    if (mdu_done) begin
                        w_state_d = HZ_RUN;
                    end else begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        if (r_wcnt_q == c_wcnt_last) begin
                            w_state_d = HZ_RUN;
                            w_err_d   = 1'b1;
                        end else begin
                            w_wcnt_d = r_wcnt_q + c_wcnt_w'(1'b1);
                        end
                    end
                end
                default: w_state_d = HZ_RUN;
            endcase
        end

        w_stall_cnt_d = r_stall_cnt_q + CNT_W'(stall_f);
        w_flush_cnt_d = r_flush_cnt_q + CNT_W'(branch_taken);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= HZ_RUN;
            r_wcnt_q      <= '0;
            r_err_q       <= 1'b0;
            r_stall_cnt_q <= '0;
            r_flush_cnt_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_wcnt_q      <= w_wcnt_d;
            r_err_q       <= w_err_d;
            r_stall_cnt_q <= w_stall_cnt_d;
            r_flush_cnt_q <= w_flush_cnt_d;
        end
    end

    assign mdu_timeout_err = r_err_q;
    assign stall_cycles    = r_stall_cnt_q;
    assign flush_events    = r_flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_ctrl
// Brief   : Self-checking bench for hazard_ctrl with a cycle-level reference
//           model; two instances cover the default and a short MDU timeout.
// Revision: 1.0
// ============================================================================
module tb_hazard_ctrl;
    import core_pkg::*;

    logic     clk = 1'b0;
    logic     rst;
    reg_idx_t d_rs1, d_rs2, e_rd;
    logic     d_rs1_used, d_rs2_used, d_valid;
    logic     e_is_load, e_valid, e_branch_taken, e_mdu_start, mdu_done;
    word_t    e_branch_target;

    logic        a_stall_f, a_stall_d, a_flush_d, a_flush_e, a_bt, a_err;
    word_t       a_tgt;
    logic [31:0] a_stalls, a_flushes;
    logic        b_stall_f, b_stall_d, b_flush_d, b_flush_e, b_bt, b_err;
    word_t       b_tgt;
    logic [31:0] b_stalls, b_flushes;

    logic [37:0] obs_a, obs_b;
    assign obs_a = {a_stall_f, a_stall_d, a_flush_d, a_flush_e, a_bt, a_tgt, a_err};
    assign obs_b = {b_stall_f, b_stall_d, b_flush_d, b_flush_e, b_bt, b_tgt, b_err};

    always #5 clk = ~clk;

    hazard_ctrl #(.MDU_TIMEOUT(64), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used), .d_valid(d_valid),
        .e_rd(e_rd), .e_is_load(e_is_load), .e_valid(e_valid),
        .e_branch_taken(e_branch_taken), .e_branch_target(e_branch_target),
        .e_mdu_start(e_mdu_start), .mdu_done(mdu_done),
        .stall_f(a_stall_f), .stall_d(a_stall_d), .flush_d(a_flush_d), .flush_e(a_flush_e),
        .branch_taken(a_bt), .branch_target(a_tgt), .mdu_timeout_err(a_err),
        .stall_cycles(a_stalls), .flush_events(a_flushes)
    );

    hazard_ctrl #(.MDU_TIMEOUT(8), .CNT_W(32)) dut8 (
        .clk(clk), .rst(rst), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used), .d_valid(d_valid),
        .e_rd(e_rd), .e_is_load(e_is_load), .e_valid(e_valid),
        .e_branch_taken(e_branch_taken), .e_branch_target(e_branch_target),
        .e_mdu_start(e_mdu_start), .mdu_done(mdu_done),
        .stall_f(b_stall_f), .stall_d(b_stall_d), .flush_d(b_flush_d), .flush_e(b_flush_e),
        .branch_taken(b_bt), .branch_target(b_tgt), .mdu_timeout_err(b_err),
        .stall_cycles(b_stalls), .flush_events(b_flushes)
    );

    // Reference model: tracks "which wait cycle are we in" rather than any counter encoding.
    typedef struct {
        bit          waiting;
        int          waited;
        bit          err;
        logic [31:0] stalls;
        logic [31:0] flushes;
    } model_t;

    model_t m64, m8;
    int     checks   = 0;
    int     failures = 0;

    // Packed as {stall_f, stall_d, flush_d, flush_e, branch_taken, branch_target, err}.
    function automatic logic [37:0] exp_out(model_t m);
        logic [37:0] r;
        logic        lu;
        r    = '0;
        r[0] = m.err;
        if (rst) return r;
        if (!m.waiting) begin
            lu = e_valid && e_is_load && d_valid && (e_rd != 5'd0) &&
                 ((d_rs1_used && d_rs1 == e_rd) || (d_rs2_used && d_rs2 == e_rd));
            if (e_branch_taken) begin
                r[35]   = 1'b1;
                r[34]   = 1'b1;
                r[33]   = 1'b1;
                r[32:1] = e_branch_target;
            end else if (lu) begin
                r[37] = 1'b1;
                r[36] = 1'b1;
                r[34] = 1'b1;
            end
        end else if (!mdu_done) begin
            r[37] = 1'b1;
            r[36] = 1'b1;
        end
        return r;
    endfunction

    function automatic model_t step(model_t m, int tmo);
        logic [37:0] e;
        model_t      n;
        e = exp_out(m);
        n = m;
        if (rst) begin
            n = '{0, 0, 0, 32'd0, 32'd0};
            return n;
        end
        n.stalls  = m.stalls + 32'(e[37]);
        n.flushes = m.flushes + 32'(e[33]);
        if (!m.waiting) begin
            if (e_valid && e_mdu_start && !e_branch_taken) begin
                n.waiting = 1;
                n.waited  = 1;
            end
        end else if (mdu_done) begin
            n.waiting = 0;
        end else if (m.waited == tmo) begin
            n.waiting = 0;
            n.err     = 1;
        end else begin
            n.waited = m.waited + 1;
        end
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        m64 = step(m64, 64);
        m8  = step(m8, 8);
        #1;
    endtask

    task automatic clear_inputs();
        d_rs1 = '0; d_rs2 = '0; e_rd = '0;
        d_rs1_used = 0; d_rs2_used = 0; d_valid = 0;
        e_is_load = 0; e_valid = 0; e_branch_taken = 0;
        e_branch_target = '0; e_mdu_start = 0; mdu_done = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        e_valid = 1; e_is_load = 1; d_valid = 1; e_rd = 5'd3; d_rs1 = 5'd3; d_rs1_used = 1;
        e_branch_taken = 1; e_branch_target = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (obs_a !== 38'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected %h", obs_a, 38'd0);
        end
        tick();
        tick();
        checks++;
        if (a_stalls !== 32'd0 || a_flushes !== 32'd0 || a_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs: got stalls=%0d flushes=%0d err=%b expected 0 0 0",
                     a_stalls, a_flushes, a_err);
        end
        rst = 1'b0;
        clear_inputs();
        #1;
    endtask

    task automatic test_load_use();
        do_reset();
        e_valid = 1; e_is_load = 1; e_rd = 5'd5; d_valid = 1; d_rs1 = 5'd5; d_rs1_used = 1;
        #1;
        checks++;
        if ({a_stall_f, a_stall_d, a_flush_d, a_flush_e, a_bt} !== 5'b11010) begin
            failures++;
            $display("FAIL load_use_ctrl: got %b expected %b",
                     {a_stall_f, a_stall_d, a_flush_d, a_flush_e, a_bt}, 5'b11010);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (a_stall_f !== 1'b0 || a_stalls !== 32'd1) begin
            failures++;
            $display("FAIL load_use_after: got stall_f=%b stalls=%0d expected 0 1", a_stall_f, a_stalls);
        end
    endtask

    task automatic test_x0_unused();
        do_reset();
        e_valid = 1; e_is_load = 1; d_valid = 1; e_rd = 5'd0; d_rs1 = 5'd0; d_rs1_used = 1;
        #1;
        checks++;
        if (a_stall_f !== 1'b0 || a_flush_e !== 1'b0) begin
            failures++;
            $display("FAIL x0_no_stall: got stall_f=%b flush_e=%b expected 0 0", a_stall_f, a_flush_e);
        end
        tick();
        e_rd = 5'd7; d_rs1 = 5'd3; d_rs2 = 5'd7; d_rs2_used = 0;
        #1;
        checks++;
        if (a_stall_f !== 1'b0 || a_stall_d !== 1'b0) begin
            failures++;
            $display("FAIL unused_rs2_no_stall: got stall_f=%b stall_d=%b expected 0 0", a_stall_f, a_stall_d);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_branch_vs_load_use();
        do_reset();
        e_valid = 1; e_is_load = 1; e_rd = 5'd9; d_valid = 1; d_rs2 = 5'd9; d_rs2_used = 1;
        e_branch_taken = 1; e_branch_target = 32'h0000_0100;
        #1;
        checks++;
        if (obs_a !== {5'b00111, 32'h0000_0100, 1'b0}) begin
            failures++;
            $display("FAIL branch_over_load_use: got %h expected %h", obs_a, {5'b00111, 32'h0000_0100, 1'b0});
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (a_flushes !== 32'd1 || a_stalls !== 32'd0 || a_tgt !== 32'd0) begin
            failures++;
            $display("FAIL branch_counters: got flushes=%0d stalls=%0d tgt=%h expected 1 0 0",
                     a_flushes, a_stalls, a_tgt);
        end
    endtask

    task automatic test_mdu();
        int n;
        do_reset();
        e_valid = 1; e_mdu_start = 1; mdu_done = 1;
        #1;
        checks++;
        if (a_stall_f !== 1'b0) begin
            failures++;
            $display("FAIL mdu_start_cycle: got stall_f=%b expected 0", a_stall_f);
        end
        tick();
        clear_inputs();
        n = 0;
        for (int k = 1; k <= 15; k++) begin
            mdu_done       = (k == 11);
            e_branch_taken = (k == 5);
            #1;
            if (a_stall_f) n++;
            if (k == 5) begin
                checks++;
                if (a_bt !== 1'b0) begin
                    failures++;
                    $display("FAIL mdu_ignores_branch: got branch_taken=%b expected 0", a_bt);
                end
            end
            tick();
        end
        clear_inputs();
        checks++;
        if (n != 10 || a_stalls !== 32'd10) begin
            failures++;
            $display("FAIL mdu_stall_len: got cycles=%0d stalls=%0d expected 10 10", n, a_stalls);
        end
        e_branch_taken = 1; e_branch_target = 32'h0000_2000;
        #1;
        checks++;
        if (a_bt !== 1'b1 || a_tgt !== 32'h0000_2000 || a_err !== 1'b0) begin
            failures++;
            $display("FAIL mdu_back_to_run: got bt=%b tgt=%h err=%b expected 1 00002000 0", a_bt, a_tgt, a_err);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        e_valid = 1; e_mdu_start = 1;
        #1;
        tick();
        clear_inputs();
        n = 0;
        for (int k = 1; k <= 12; k++) begin
            #1;
            if (b_stall_f) n++;
            tick();
        end
        checks++;
        if (n != 8 || b_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_release: got cycles=%0d err=%b expected 8 1", n, b_err);
        end
        e_valid = 1; e_mdu_start = 1;
        #1;
        tick();
        mdu_done = 1; e_mdu_start = 0;
        #1;
        tick();
        clear_inputs();
        #1;
        checks++;
        if (b_err !== 1'b1 || b_stall_f !== 1'b0) begin
            failures++;
            $display("FAIL timeout_sticky: got err=%b stall_f=%b expected 1 0", b_err, b_stall_f);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        e_valid = 1; e_mdu_start = 1;
        #1;
        tick();
        clear_inputs();
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (obs_a[37:1] !== 37'd0) begin
            failures++;
            $display("FAIL reset_wait_gating: got %h expected 0", obs_a[37:1]);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (a_stall_f !== 1'b0 || a_stalls !== 32'd0 || a_flushes !== 32'd0 || a_err !== 1'b0 ||
            b_stall_f !== 1'b0 || b_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_wait: got stall_f=%b stalls=%0d flushes=%0d err=%b b_stall=%b b_err=%b expected all 0",
                     a_stall_f, a_stalls, a_flushes, a_err, b_stall_f, b_err);
        end
    endtask

    task automatic test_random();
        logic [37:0] ea, eb;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst             = ($urandom_range(0, 299) == 0);
            d_rs1           = 5'($urandom_range(0, 3));
            d_rs2           = 5'($urandom_range(0, 3));
            e_rd            = 5'($urandom_range(0, 3));
            d_rs1_used      = ($urandom_range(0, 3) != 0);
            d_rs2_used      = ($urandom_range(0, 1) != 0);
            d_valid         = ($urandom_range(0, 7) != 0);
            e_valid         = ($urandom_range(0, 7) != 0);
            e_is_load       = ($urandom_range(0, 2) == 0);
            e_branch_taken  = ($urandom_range(0, 9) == 0);
            e_branch_target = $urandom;
            e_mdu_start     = ($urandom_range(0, 14) == 0);
            mdu_done        = ($urandom_range(0, 12) == 0);
            #1;
            ea = exp_out(m64);
            eb = exp_out(m8);
            checks++;
            if (obs_a !== ea || a_stalls !== m64.stalls || a_flushes !== m64.flushes) begin
                failures++;
                $display("FAIL random_t64 cyc=%0d: got %h/%0d/%0d expected %h/%0d/%0d",
                         c, obs_a, a_stalls, a_flushes, ea, m64.stalls, m64.flushes);
            end
            checks++;
            if (obs_b !== eb || b_stalls !== m8.stalls || b_flushes !== m8.flushes) begin
                failures++;
                $display("FAIL random_t8 cyc=%0d: got %h/%0d/%0d expected %h/%0d/%0d",
                         c, obs_b, b_stalls, b_flushes, eb, m8.stalls, m8.flushes);
            end
            tick();
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        m64 = '{0, 0, 0, 32'd0, 32'd0};
        m8  = '{0, 0, 0, 32'd0, 32'd0};
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_x0_unused();
        test_branch_vs_load_use();
        test_mdu();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage core. Watches the decode and execute stages and drives the fetch stage's `stall_f`, `branch_taken` and `branch_target` inputs, plus decode/execute stall and flush controls. Handles three cases:
- load-use interlock;
- taken-branch redirect;
- multi-cycle MDU (mul/div) occupancy.

Also keeps stall/flush performance counters. It sits beside the datapath, between EX-stage resolution logic and fetch.

## Interface
Parameters:
- `MDU_TIMEOUT`, default 64: maximum MDU wait cycles before forced release and sticky error.
- `CNT_W`, default 32: performance counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `d_rs1`, `d_rs2` in 5: source registers of the instruction in decode.
- `d_rs1_used`, `d_rs2_used` in 1: source actually read.
- `d_valid` in 1: decode holds a real instruction.
- `e_rd` in 5: destination of the instruction in EX.
- `e_is_load`, `e_valid` in 1: EX instruction is a load; EX valid.
- `e_branch_taken` in 1: EX resolved a taken branch or jump this cycle.
- `e_branch_target` in word_t: resolved target.
- `e_mdu_start` in 1: EX issues a multi-cycle MDU op this cycle.
- `mdu_done` in 1: MDU result ready.
- `stall_f` out 1: to fetch; hold PC.
- `stall_d` out 1: hold decode register.
- `flush_d` out 1: squash decode register next edge.
- `flush_e` out 1: insert bubble into EX next edge.
- `branch_taken` out 1, `branch_target` out word_t: redirect to fetch.
- `mdu_timeout_err` out 1: sticky.
- `stall_cycles` out CNT_W, `flush_events` out CNT_W: performance counters.

## Operation
FSM states: RUN, MDU_WAIT.

- **RUN**
  - Load-use hazard: `e_valid & e_is_load & d_valid & e_rd != 0 & ((d_rs1_used & d_rs1 == e_rd) | (d_rs2_used & d_rs2 == e_rd))`. When true, assert `stall_f`, `stall_d` and `flush_e` for exactly that cycle. The hazard clears next cycle because the load has moved past EX.
  - `e_mdu_start` (while `e_valid`, no branch): go to MDU_WAIT; clear the wait counter.
- **MDU_WAIT**
  - Each cycle: assert `stall_f`, `stall_d`, and a stall for EX, expressed as `flush_e=0` with the EX register held by the datapath via `stall_d`.
  - Return to RUN on `mdu_done`. Outputs are deasserted in the done cycle.
  - Counter reaching `MDU_TIMEOUT-1` without `mdu_done`: force RUN and set `mdu_timeout_err`. It stays set until reset.

Branch redirect:
- `e_branch_taken` in RUN drives `branch_taken=1` and `branch_target=e_branch_target` combinationally, same cycle. It also asserts `flush_d` and `flush_e` for that cycle.
- Redirect overrides load-use: no stall is issued. `stall_f` must be 0 so fetch takes the target.
- `e_mdu_start` coincident with `e_branch_taken` is illegal (single EX instruction). The branch wins and MDU_WAIT is not entered.

Other rules:
- In MDU_WAIT, `e_branch_taken` is ignored, because the EX instruction is the MDU op.
- `branch_target` is 0 when `branch_taken=0`.

Counters:
- `stall_cycles` increments every cycle `stall_f=1`.
- `flush_events` increments every cycle `branch_taken=1`.
- Both wrap modulo 2^CNT_W.

## Timing
- Reset values:
  - state RUN;
  - all control outputs 0;
  - `branch_target` 0;
  - counters 0;
  - `mdu_timeout_err` 0.
- Control outputs are combinational from state plus inputs: zero-cycle latency, so they are valid in the same cycle as the hazard.
- Only the state, wait counter, error flag and perf counters are registered.
- Reset mid-MDU_WAIT returns to RUN on that edge. Outputs are 0 in the first post-reset cycle regardless of inputs, because `rst` gates all control outputs to 0.
- `mdu_done` in the same cycle as `e_mdu_start` in RUN: ignored, and MDU_WAIT is still entered. `mdu_done` is only sampled in MDU_WAIT.
- Timeout: forced release occurs on the edge ending wait cycle `MDU_TIMEOUT`. The stall covers exactly `MDU_TIMEOUT` cycles.

## Structure
- Shared core package (`core_pkg`): `word_t` (32-bit), `reg_idx_t` (5-bit), state enum `hz_state_t`.
- Optional sub-module `hz_loaduse_detect`: pure comparator producing the load-use flag. Everything else stays in `hazard_ctrl`.

## Test plan
- **Load-use:** `e_is_load=1`, `e_rd=5`, `d_rs1=5`, `d_rs1_used=1`, all valid. Required: `stall_f`, `stall_d`, `flush_e` all =1 for one cycle; `stall_cycles` goes to 1.
- **x0 / unused source:** `e_rd=0` with `d_rs1=0`; then `e_rd=7`, `d_rs2=7`, `d_rs2_used=0`. Required: no stall in either case.
- **Branch vs load-use:** `e_branch_taken=1`, `e_branch_target=0x100` together with a load-use match. Required: `branch_taken=1`, `branch_target=0x100`, `flush_d=flush_e=1`, `stall_f=0`; `flush_events=1`.
- **MDU:** `e_mdu_start` pulse, `mdu_done` 10 cycles later. Required: `stall_f=1` for exactly 10 cycles, then state RUN; `stall_cycles=10`.
- **Timeout:** `MDU_TIMEOUT=8`, `mdu_done` never asserted. Required: stall for 8 cycles, then release with `mdu_timeout_err=1` held thereafter.
- **Reset mid-wait:** `rst` asserted on the 3rd MDU_WAIT cycle. Required: next cycle state RUN; all outputs and counters 0; `mdu_timeout_err=0`.
